counter_sweep_ctrl: RTL and testbench
=====================================

# counter_sweep_ctrl

Sequencer that drives the control inputs of the team's 4-bit up/down counter (`counter`: enable, up_down, count_load, load_value) to run a programmed triangle sweep. It loads a floor value, counts up to a ceiling, counts back down to the floor, and repeats a programmed number of times. It reports busy/done/error status to the host. It sits beside the counter and reads back the counter's `count` output to decide each step.

## Interface
- `WIDTH`, 4: counter data width.
- `REP_W`, 4: width of the repeat count and sweep counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a run. Sampled only in IDLE.
- `abort` in 1: cancel a run in progress.
- `cfg_lo` in WIDTH: sweep floor. Latched on accepted start.
- `cfg_hi` in WIDTH: sweep ceiling. Latched on accepted start.
- `cfg_reps` in REP_W: number of full up+down sweeps. Latched on accepted start.
- `cnt_value` in WIDTH: the counter's `count` output.
- `cnt_enable` out 1: drives the counter's `enable`.
- `cnt_up_down` out 1: drives the counter's `up_down`. 1 = up, 0 = down.
- `cnt_load` out 1: drives the counter's `count_load`.
- `cnt_load_value` out WIDTH: drives the counter's `load_value`.
- `busy` out 1: high in LOAD, UP and DOWN.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: one-cycle registered pulse when start is rejected.
- `sweeps` out REP_W: completed sweeps in the current or last run.

## Operation
- Counter contract:
  - The counter is registered.
  - count_load has priority over enable.
  - enable steps the count by ±1 per clock.
- States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE:
  - All counter controls are 0.
  - On `start`: if `cfg_lo <= cfg_hi` and `cfg_reps != 0`, latch lo_q/hi_q/reps_q, clear `sweeps`, go to LOAD.
  - Otherwise pulse `err` next cycle and stay in IDLE.
- LOAD (1 cycle):
  - `cnt_load=1`, `cnt_load_value=lo_q`, `cnt_enable=0`.
  - Go to UP.
- UP:
  - `cnt_up_down=1`, `cnt_enable = (cnt_value < hi_q)`.
  - When `cnt_value >= hi_q`, go to DOWN. This gives a one-cycle dwell at the ceiling.
- DOWN:
  - `cnt_up_down=0`, `cnt_enable = (cnt_value > lo_q)`.
  - When `cnt_value <= lo_q`, increment `sweeps`.
  - If `sweeps + 1 == reps_q`, go to DONE; otherwise go to UP. This gives a one-cycle dwell at the floor.
- DONE (1 cycle): `done=1`, `busy=0`, controls 0, then go to IDLE.
- `abort` while busy:
  - Next state is IDLE and controls are 0 from the next cycle.
  - No `done` pulse; `sweeps` holds its value.
  - `abort` in IDLE or DONE has no effect.
- `start` while busy or in DONE is ignored.
- The `>=` / `<=` comparisons make the block robust: an out-of-range `cnt_value` terminates the phase instead of wrapping.
- Counter control outputs are combinational decode of state and `cnt_value`; `cnt_load_value` is lo_q at all times.
- Arithmetic:
  - Comparisons are unsigned WIDTH-bit.
  - The `sweeps` increment saturates at `2^REP_W-1`. It cannot overflow, since `reps_q <= 2^REP_W-1`.

## Timing
- Start accepted at edge k: LOAD during cycle k+1, and the counter holds lo_q from edge k+2.
- Busy duration: `1 + reps*2*(hi-lo+1)` cycles, then a 1-cycle DONE.
- `lo == hi`: each sweep takes 2 cycles with `cnt_enable=0` throughout.
- Latency from `start` to `err`: 1 cycle.
- Reset values: state IDLE, and all outputs 0, including `sweeps=0`, `done=0`, `err=0`, `busy=0`.
- Reset mid-run returns to IDLE on the same edge. The counter keeps its last value.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the `sweep_state_t` enum (IDLE, LOAD, UP, DOWN, DONE);
  - constants `DIR_UP=1'b1` and `DIR_DOWN=1'b0`.
- Single flat module: FSM, config latches, sweep counter; no sub-module.
- The existing `counter` is instantiated alongside it by the integrating wrapper, not inside this block.

## Test plan
- lo=2, hi=4, reps=1, counter attached:
  - count sequence after LOAD is 2,3,4,4,3,2;
  - busy is high for 7 cycles;
  - `done` pulses once;
  - `sweeps`=1.
- lo=0, hi=15, reps=3: count stays in 0..15 with no wrap, `sweeps` ends at 3, and busy lasts 97 cycles.
- lo=5, hi=3 or reps=0: `err` pulses 1 cycle after start, busy stays 0, counter controls stay 0.
- lo=hi=7, reps=2: `cnt_enable` stays 0, busy lasts 5 cycles, count holds at 7.
- abort in the 2nd sweep of a reps=4 run:
  - IDLE next cycle;
  - no `done`;
  - `sweeps`=1;
  - a new start then runs correctly.
- rst asserted mid-DOWN: all outputs are 0 on the next cycle, and `start` held high during busy is ignored.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and direction constants for the counter sweep sequencer
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } sweep_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - drives an external up/down counter through repeated floor-to-ceiling triangle sweeps
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] sweeps
);

    sweep_state_t     state, state_n;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] sweeps_inc;
    logic             accept, reject, sweep_end;

    // Saturating increment; reps_q caps the run well before this matters.
    assign sweeps_inc     = (sweeps == {REP_W{1'b1}}) ? sweeps : sweeps + REP_W'(1);
    assign cnt_load_value = lo_q;

    always_comb begin
        state_n     = state;
        cnt_enable  = 1'b0;
        cnt_up_down = DIR_DOWN;
        cnt_load    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        sweep_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((cfg_lo <= cfg_hi) && (cfg_reps != '0)) begin
                        accept  = 1'b1;
                        state_n = LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOAD: begin
                busy     = 1'b1;
                cnt_load = 1'b1;
                state_n  = UP;
            end
            UP: begin
                busy        = 1'b1;
                cnt_up_down = DIR_UP;
                cnt_enable  = (cnt_value < hi_q);
                if (cnt_value >= hi_q) state_n = DOWN;
            end
            DOWN: begin
                busy        = 1'b1;
                cnt_up_down = DIR_DOWN;
                cnt_enable  = (cnt_value > lo_q);
                if (cnt_value <= lo_q) begin
                    sweep_end = 1'b1;
                    state_n   = (sweeps_inc == reps_q) ? DONE : UP;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Abort freezes the sweep count, even if it lands on a floor dwell.
        if (abort && busy) begin
            state_n   = IDLE;
            sweep_end = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lo_q   <= '0;
            hi_q   <= '0;
            reps_q <= '0;
            sweeps <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            err   <= reject;
            if (accept) begin
                lo_q   <= cfg_lo;
                hi_q   <= cfg_hi;
                reps_q <= cfg_reps;
                sweeps <= '0;
            end else if (sweep_end) begin
                sweeps <= sweeps_inc;
            end
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - directed bench for counter_sweep_ctrl with an attached behavioural counter
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_lo = '0;
    logic [3:0] cfg_hi = '0;
    logic [3:0] cfg_reps = '0;
    logic [3:0] cnt_value;
    logic       cnt_enable, cnt_up_down, cnt_load;
    logic [3:0] cnt_load_value;
    logic       busy, done, err;
    logic [3:0] sweeps;

    logic [3:0] cnt = 4'd0;
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (cnt_load)        cnt <= cnt_load_value;
        else if (cnt_enable) cnt <= cnt_up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign cnt_value = cnt;

    counter_sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_reps(cfg_reps),
        .cnt_value(cnt_value), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down),
        .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
        .busy(busy), .done(done), .err(err), .sweeps(sweeps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " enable"}, cnt_enable, 0);
        chk({tag, " load"}, cnt_load, 0);
        chk({tag, " up_down"}, cnt_up_down, 0);
    endtask

    task automatic run_sweep(input logic [3:0] lo, input logic [3:0] hi,
                             input logic [3:0] reps, input string tag);
        int exp_busy;
        int busy_cyc;
        int guard;
        bit en_seen;
        exp_q.delete();
        for (int r = 0; r < int'(reps); r++) begin
            for (int v = int'(lo); v <= int'(hi); v++) exp_q.push_back(4'(v));
            for (int v = int'(hi); v >= int'(lo); v--) exp_q.push_back(4'(v));
        end
        exp_busy = 1 + int'(reps) * 2 * (int'(hi) - int'(lo) + 1);
        cfg_lo = lo; cfg_hi = hi; cfg_reps = reps;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({tag, " load"}, cnt_load, 1);
        chk({tag, " load_value"}, cnt_load_value, lo);
        chk({tag, " busy_at_load"}, busy, 1);
        busy_cyc = 1;
        guard = 0;
        en_seen = 0;
        @(negedge clk);
        while (busy && guard < 2000) begin
            busy_cyc++;
            guard++;
            if (cnt_enable) en_seen = 1;
            if (exp_q.size() > 0) chk({tag, " count"}, cnt_value, exp_q.pop_front());
            @(negedge clk);
        end
        chk({tag, " no_timeout"}, guard < 2000, 1);
        chk({tag, " done_pulse"}, done, 1);
        chk({tag, " busy_cycles"}, busy_cyc, exp_busy);
        chk({tag, " sweeps"}, sweeps, reps);
        chk({tag, " scoreboard_drained"}, exp_q.size(), 0);
        if (lo == hi) chk({tag, " enable_never"}, en_seen, 0);
        @(negedge clk);
        chk({tag, " done_single"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    task automatic err_case(input logic [3:0] lo, input logic [3:0] hi,
                            input logic [3:0] reps, input string tag);
        cfg_lo = lo; cfg_hi = hi; cfg_reps = reps;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({tag, " err"}, err, 1);
        chk_quiet(tag);
        @(negedge clk);
        chk({tag, " err_single"}, err, 0);
        chk_quiet({tag, " after"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");
        chk("reset err", err, 0);
        chk("reset sweeps", sweeps, 0);
        chk("reset load_value", cnt_load_value, 0);

        run_sweep(4'd2, 4'd4, 4'd1, "basic");
        run_sweep(4'd0, 4'd15, 4'd3, "full_range");
        err_case(4'd5, 4'd3, 4'd1, "lo_gt_hi");
        err_case(4'd1, 4'd3, 4'd0, "zero_reps");
        run_sweep(4'd7, 4'd7, 4'd2, "flat");

        // abort during the second sweep of a four-sweep run
        cfg_lo = 4'd1; cfg_hi = 4'd3; cfg_reps = 4'd4;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort pre busy", busy, 1);
        chk("abort pre sweeps", sweeps, 1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk_quiet("abort");
        chk("abort sweeps", sweeps, 1);
        repeat (3) begin
            @(negedge clk);
            chk("abort no_done", done, 0);
        end
        run_sweep(4'd0, 4'd2, 4'd1, "after_abort");

        // reset mid-DOWN with start held high throughout the run
        cfg_lo = 4'd0; cfg_hi = 4'd5; cfg_reps = 4'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold load", cnt_load, 1);
        repeat (8) begin
            @(negedge clk);
            chk("hold busy", busy, 1);
            chk("hold no_reload", cnt_load, 0);
        end
        chk("hold in_down", cnt_up_down, 0);
        #1 start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("mid_reset");
        chk("mid_reset err", err, 0);
        chk("mid_reset sweeps", sweeps, 0);
        chk("mid_reset load_value", cnt_load_value, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
